// File: rtl/st7735_spi_decoder_pkg.sv
// ST7735 shared constants: command codes, decoder FSM encoding and a
// small helper for loading one byte of a 16-bit window register.
package st7735_spi_decoder_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CASET_P  = 3'd1,
    ST_RASET_P  = 3'd2,
    ST_RAMWR_HI = 3'd3,
    ST_RAMWR_LO = 3'd4
  } dec_state_t;

  // Replace the high or low byte of a 16-bit value.
  function automatic logic [15:0] set_byte(input logic [15:0] value,
                                           input logic        hi,
                                           input logic [7:0]  b);
    logic [15:0] result;
    if (hi) begin
      result = {b, value[7:0]};
    end else begin
      result = {value[15:8], b};
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: synchronises the asynchronous panel pins into the
// SYSTEM_CLK domain, detects LCD_CLK rising edges, shifts MOSI MSB first
// and emits a one-cycle byte strobe together with the DC flag.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       lcd_clk,
  input  logic       mosi,
  input  logic       dc,
  input  logic       lcd_reset,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       srst
);

  logic [1:0] cs_sync_r;
  logic [1:0] clk_sync_r;
  logic [1:0] mosi_sync_r;
  logic [1:0] dc_sync_r;
  logic [1:0] rst_sync_r;
  logic       clk_prev_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic       byte_valid_r;
  logic [7:0] byte_data_r;
  logic       byte_dc_r;

  logic cs_s;
  logic mosi_s;
  logic dc_s;
  logic srst_s;
  logic sclk_rise_s;

  assign cs_s        = cs_sync_r[1];
  assign mosi_s      = mosi_sync_r[1];
  assign dc_s        = dc_sync_r[1];
  assign srst_s      = ~rst_sync_r[1];
  assign sclk_rise_s = clk_sync_r[1] & ~clk_prev_r;

  // Two-flop synchronisers; reset values match an idle, deselected bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_r   <= 2'b11;
      clk_sync_r  <= 2'b00;
      mosi_sync_r <= 2'b00;
      dc_sync_r   <= 2'b00;
      rst_sync_r  <= 2'b11;
    end else begin
      cs_sync_r   <= {cs_sync_r[0], cs};
      clk_sync_r  <= {clk_sync_r[0], lcd_clk};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      dc_sync_r   <= {dc_sync_r[0], dc};
      rst_sync_r  <= {rst_sync_r[0], lcd_reset};
    end
  end

  // Edge detect, shifter and bit counter; a partial byte is dropped while deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_r   <= 1'b0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 7'd0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
      byte_dc_r    <= 1'b0;
    end else begin
      clk_prev_r   <= clk_sync_r[1];
      byte_valid_r <= 1'b0;
      if (srst_s || cs_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        shift_r   <= {shift_r[5:0], mosi_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_valid_r <= 1'b1;
          byte_data_r  <= {shift_r, mosi_s};
          byte_dc_r    <= dc_s;
        end
      end
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign byte_dc    = byte_dc_r;
  assign srst       = srst_s;

endmodule

// File: rtl/st7735_spi_decoder.sv
// ST7735 SPI decoder: turns the panel's SPI command/data stream into
// command strobes and addressed RGB565 pixel writes inside the
// CASET/RASET window.
module st7735_spi_decoder
  import st7735_spi_decoder_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 160
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESET_N,
  input  logic        CS,
  input  logic        LCD_CLK,
  input  logic        MOSI,
  input  logic        DC,
  input  logic        LCD_RESET,
  output logic        CMD_VALID,
  output logic [7:0]  CMD,
  output logic        PIXEL_VALID,
  output logic [7:0]  PIXEL_X,
  output logic [7:0]  PIXEL_Y,
  output logic [15:0] PIXEL_DATA
);

  localparam logic [15:0] X_END_RST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_END_RST = 16'(HEIGHT - 1);

  logic       byte_valid_s;
  logic [7:0] byte_s;
  logic       byte_dc_s;
  logic       srst_s;

  dec_state_t  state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic [15:0] xs_r, xs_s, xe_r, xe_s, ys_r, ys_s, ye_r, ye_s;
  logic [15:0] x_r, x_s, y_r, y_s;
  logic [7:0]  cmd_r, cmd_s;
  logic        cmd_valid_r, cmd_valid_s;
  logic        pixel_valid_r, pixel_valid_s;
  logic [7:0]  pixel_x_r, pixel_x_s, pixel_y_r, pixel_y_s;
  logic [15:0] pixel_data_r, pixel_data_s;

  spi_byte_rx u_rx (
    .clk        (SYSTEM_CLK),
    .rst_n      (RESET_N),
    .cs         (CS),
    .lcd_clk    (LCD_CLK),
    .mosi       (MOSI),
    .dc         (DC),
    .lcd_reset  (LCD_RESET),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_s),
    .byte_dc    (byte_dc_s),
    .srst       (srst_s)
  );

  // Next-state decode: panel reset, then commands, then data bytes by state.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    xs_s          = xs_r;
    xe_s          = xe_r;
    ys_s          = ys_r;
    ye_s          = ye_r;
    x_s           = x_r;
    y_s           = y_r;
    cmd_s         = cmd_r;
    cmd_valid_s   = 1'b0;
    pixel_valid_s = 1'b0;
    pixel_x_s     = pixel_x_r;
    pixel_y_s     = pixel_y_r;
    pixel_data_s  = pixel_data_r;

    if (srst_s) begin
      // Panel reset pin behaves like SWRESET without a command strobe.
      state_s = ST_IDLE;
      idx_s   = 2'd0;
      xs_s    = 16'd0;
      xe_s    = X_END_RST;
      ys_s    = 16'd0;
      ye_s    = Y_END_RST;
    end else if (byte_valid_s && !byte_dc_s) begin
      cmd_valid_s = 1'b1;
      cmd_s       = byte_s;
      idx_s       = 2'd0;
      case (byte_s)
        CMD_SWRESET: begin
          state_s = ST_IDLE;
          xs_s    = 16'd0;
          xe_s    = X_END_RST;
          ys_s    = 16'd0;
          ye_s    = Y_END_RST;
        end
        CMD_CASET: state_s = ST_CASET_P;
        CMD_RASET: state_s = ST_RASET_P;
        CMD_RAMWR: begin
          x_s     = xs_r;
          y_s     = ys_r;
          state_s = ST_RAMWR_HI;
        end
        default: state_s = ST_IDLE;
      endcase
    end else if (byte_valid_s) begin
      case (state_r)
        ST_CASET_P: begin
          // Parameter order: start hi, start lo, end hi, end lo.
          if (idx_r[1]) begin
            xe_s = set_byte(xe_r, ~idx_r[0], byte_s);
          end else begin
            xs_s = set_byte(xs_r, ~idx_r[0], byte_s);
          end
          idx_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_CASET_P;
          end
        end
        ST_RASET_P: begin
          if (idx_r[1]) begin
            ye_s = set_byte(ye_r, ~idx_r[0], byte_s);
          end else begin
            ys_s = set_byte(ys_r, ~idx_r[0], byte_s);
          end
          idx_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RASET_P;
          end
        end
        ST_RAMWR_HI: begin
          pixel_data_s = {byte_s, pixel_data_r[7:0]};
          state_s      = ST_RAMWR_LO;
        end
        ST_RAMWR_LO: begin
          pixel_data_s  = {pixel_data_r[15:8], byte_s};
          pixel_valid_s = 1'b1;
          pixel_x_s     = x_r[7:0];
          pixel_y_s     = y_r[7:0];
          state_s       = ST_RAMWR_HI;
          // Raster advance with wrap back to the window origin.
          if (x_r == xe_r) begin
            x_s = xs_r;
            if (y_r == ye_r) begin
              y_s = ys_r;
            end else begin
              y_s = y_r + 16'd1;
            end
          end else begin
            x_s = x_r + 16'd1;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= ST_IDLE;
      idx_r         <= 2'd0;
      xs_r          <= 16'd0;
      xe_r          <= X_END_RST;
      ys_r          <= 16'd0;
      ye_r          <= Y_END_RST;
      x_r           <= 16'd0;
      y_r           <= 16'd0;
      cmd_r         <= 8'h00;
      cmd_valid_r   <= 1'b0;
      pixel_valid_r <= 1'b0;
      pixel_x_r     <= 8'd0;
      pixel_y_r     <= 8'd0;
      pixel_data_r  <= 16'd0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      xs_r          <= xs_s;
      xe_r          <= xe_s;
      ys_r          <= ys_s;
      ye_r          <= ye_s;
      x_r           <= x_s;
      y_r           <= y_s;
      cmd_r         <= cmd_s;
      cmd_valid_r   <= cmd_valid_s;
      pixel_valid_r <= pixel_valid_s;
      pixel_x_r     <= pixel_x_s;
      pixel_y_r     <= pixel_y_s;
      pixel_data_r  <= pixel_data_s;
    end
  end

  assign CMD_VALID   = cmd_valid_r;
  assign CMD         = cmd_r;
  assign PIXEL_VALID = pixel_valid_r;
  assign PIXEL_X     = pixel_x_r;
  assign PIXEL_Y     = pixel_y_r;
  assign PIXEL_DATA  = pixel_data_r;

endmodule

// File: tb/tb_st7735_spi_decoder.sv
// Scoreboard bench for st7735_spi_decoder: a window/pixel-count reference
// model queues expected commands and pixels; a monitor compares them as
// the DUT strobes its outputs.
module tb_st7735_spi_decoder;

  localparam int W = 128;
  localparam int H = 160;

  logic        SYSTEM_CLK = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        CS         = 1'b1;
  logic        LCD_CLK    = 1'b0;
  logic        MOSI       = 1'b0;
  logic        DC         = 1'b0;
  logic        LCD_RESET  = 1'b1;
  logic        CMD_VALID;
  logic [7:0]  CMD;
  logic        PIXEL_VALID;
  logic [7:0]  PIXEL_X;
  logic [7:0]  PIXEL_Y;
  logic [15:0] PIXEL_DATA;

  st7735_spi_decoder #(.WIDTH(W), .HEIGHT(H)) dut (
    .SYSTEM_CLK  (SYSTEM_CLK),
    .RESET_N     (RESET_N),
    .CS          (CS),
    .LCD_CLK     (LCD_CLK),
    .MOSI        (MOSI),
    .DC          (DC),
    .LCD_RESET   (LCD_RESET),
    .CMD_VALID   (CMD_VALID),
    .CMD         (CMD),
    .PIXEL_VALID (PIXEL_VALID),
    .PIXEL_X     (PIXEL_X),
    .PIXEL_Y     (PIXEL_Y),
    .PIXEL_DATA  (PIXEL_DATA)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  cmd_q[$];
  logic [31:0] pix_q[$];

  // Reference model: window as four integers, pixel position from pixel count.
  int         m_mode;      // 0 idle, 1 column params, 2 row params, 3 high byte, 4 low byte
  int         m_idx;
  int         m_win[4];    // xs, xe, ys, ye
  int         m_pix_n;
  logic [7:0] m_hi;
  logic [7:0] m_last_cmd;

  function automatic void model_swreset();
    m_win  = '{0, W - 1, 0, H - 1};
    m_mode = 0;
  endfunction

  function automatic void model_byte(input logic dc, input logic [7:0] d);
    int slot, w, h, x, y;
    logic [15:0] v;
    if (!dc) begin
      cmd_q.push_back(d);
      m_last_cmd = d;
      m_idx = 0;
      if (d == 8'h01) model_swreset();
      else if (d == 8'h2A) m_mode = 1;
      else if (d == 8'h2B) m_mode = 2;
      else if (d == 8'h2C) begin m_mode = 3; m_pix_n = 0; end
      else m_mode = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      slot = ((m_mode == 1) ? 0 : 2) + m_idx / 2;
      v = m_win[slot][15:0];
      if (m_idx % 2 == 0) v[15:8] = d;
      else v[7:0] = d;
      m_win[slot] = int'(v);
      m_idx++;
      if (m_idx == 4) m_mode = 0;
    end else if (m_mode == 3) begin
      m_hi = d;
      m_mode = 4;
    end else if (m_mode == 4) begin
      w = m_win[1] - m_win[0] + 1;
      h = m_win[3] - m_win[2] + 1;
      x = m_win[0] + m_pix_n % w;
      y = m_win[2] + (m_pix_n / w) % h;
      pix_q.push_back({x[7:0], y[7:0], m_hi, d});
      m_pix_n++;
      m_mode = 3;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, expv);
    end
  endtask

  // Shift nbits of d (MSB first) at LCD_CLK = SYSTEM_CLK/4.
  task automatic spi_bits(input logic dc, input logic [7:0] d, input int nbits);
    @(negedge SYSTEM_CLK);
    DC = dc;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = d[i];
      LCD_CLK = 1'b0;
      #20;
      LCD_CLK = 1'b1;
      #20;
    end
    LCD_CLK = 1'b0;
  endtask

  task automatic send(input logic dc, input logic [7:0] d);
    model_byte(dc, d);
    spi_bits(dc, d, 8);
    #60;
  endtask

  task automatic cmd(input logic [7:0] d);
    send(1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    send(1'b1, d);
  endtask

  task automatic pixel(input logic [15:0] p);
    dat(p[15:8]);
    dat(p[7:0]);
  endtask

  task automatic set_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    cmd(c);
    dat(s[15:8]); dat(s[7:0]); dat(e[15:8]); dat(e[7:0]);
  endtask

  task automatic lcd_reset_pulse();
    @(negedge SYSTEM_CLK);
    LCD_RESET = 1'b0;
    model_swreset();
    repeat (10) @(negedge SYSTEM_CLK);
    LCD_RESET = 1'b1;
    repeat (4) @(negedge SYSTEM_CLK);
  endtask

  task automatic partial_byte(input int nbits);
    logic [7:0] junk;
    junk = 8'($urandom);
    spi_bits(1'($urandom), junk, nbits);
    CS = 1'b1;
    #100;
    CS = 1'b0;
    #100;
  endtask

  // Monitor: pop and compare on every output strobe.
  logic [7:0]  exp_cmd;
  logic [31:0] exp_pix;
  always @(negedge SYSTEM_CLK) begin
    if (RESET_N) begin
      if (CMD_VALID) begin
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected got %02h expected none", CMD);
        end else begin
          exp_cmd = cmd_q.pop_front();
          if (CMD !== exp_cmd) begin
            errors++;
            $display("FAIL cmd got %02h expected %02h", CMD, exp_cmd);
          end
        end
      end
      if (PIXEL_VALID) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_unexpected got (%0d,%0d) %04h expected none",
                   PIXEL_X, PIXEL_Y, PIXEL_DATA);
        end else begin
          exp_pix = pix_q.pop_front();
          if ({PIXEL_X, PIXEL_Y, PIXEL_DATA} !== exp_pix) begin
            errors++;
            $display("FAIL pixel got (%0d,%0d) %04h expected (%0d,%0d) %04h",
                     PIXEL_X, PIXEL_Y, PIXEL_DATA,
                     exp_pix[31:24], exp_pix[23:16], exp_pix[15:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] s, e;
    int n;
    model_swreset();
    m_idx = 0;
    m_pix_n = 0;
    m_hi = 8'h00;
    m_last_cmd = 8'h00;

    // Reset state.
    #22;
    chk("rst_cmd_valid", {31'd0, CMD_VALID}, 32'd0);
    chk("rst_pixel_valid", {31'd0, PIXEL_VALID}, 32'd0);
    chk("rst_cmd", {24'd0, CMD}, 32'h00);
    chk("rst_pixel_x", {24'd0, PIXEL_X}, 32'd0);
    chk("rst_pixel_y", {24'd0, PIXEL_Y}, 32'd0);
    chk("rst_pixel_data", {16'd0, PIXEL_DATA}, 32'd0);
    @(negedge SYSTEM_CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge SYSTEM_CLK);
    CS = 1'b0;
    #100;

    // Column window 2..5, row window 3..4, 8 red pixels then one green wrap.
    set_win(8'h2A, 16'd2, 16'd5);
    chk("caset_cmd_held", {24'd0, CMD}, 32'h2A);
    set_win(8'h2B, 16'd3, 16'd4);
    cmd(8'h2C);
    for (int i = 0; i < 8; i++) pixel(16'hF800);
    pixel(16'h07E0);
    chk("wrap_x", {24'd0, PIXEL_X}, 32'd2);
    chk("wrap_y", {24'd0, PIXEL_Y}, 32'd3);
    chk("wrap_data", {16'd0, PIXEL_DATA}, 32'h07E0);

    // Partial byte with CS deasserted, then a clean command.
    spi_bits(1'b0, 8'hFF, 5);
    CS = 1'b1;
    #100;
    CS = 1'b0;
    #100;
    cmd(8'h2C);

    // Half pixel abandoned by a new command; later data ignored in idle.
    cmd(8'h2C);
    dat(8'hAB);
    cmd(8'h00);
    chk("abort_cmd", {24'd0, CMD}, 32'h00);
    dat(8'h55);
    dat(8'h66);

    // SWRESET window: origin pixel, then row wrap at X=127.
    cmd(8'h01);
    cmd(8'h2C);
    pixel(16'h001F);
    for (int i = 0; i < W; i++) pixel(16'($urandom));

    // Panel reset pin behaves like SWRESET.
    set_win(8'h2A, 16'd10, 16'd12);
    lcd_reset_pulse();
    cmd(8'h2C);
    pixel(16'h001F);

    // Frame wrap at the panel corner.
    set_win(8'h2A, 16'd126, 16'd127);
    set_win(8'h2B, 16'd158, 16'd159);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) pixel(16'($urandom));

    // Randomised operations.
    for (int op = 0; op < 25; op++) begin
      case ($urandom_range(0, 6))
        0: begin
          s = 16'($urandom_range(0, 300));
          e = s + 16'($urandom_range(0, 4));
          set_win(8'h2A, s, e);
        end
        1: begin
          s = 16'($urandom_range(0, 300));
          e = s + 16'($urandom_range(0, 4));
          set_win(8'h2B, s, e);
        end
        2: begin
          cmd(8'h2C);
          n = $urandom_range(1, 12);
          for (int i = 0; i < n; i++) pixel(16'($urandom));
        end
        3: begin
          s[7:0] = 8'($urandom);
          if (s[7:0] == 8'h2A || s[7:0] == 8'h2B) s[7:0] = 8'h00;
          cmd(s[7:0]);
          dat(8'($urandom));
          dat(8'($urandom));
        end
        4: begin
          cmd(8'h2C);
          pixel(16'($urandom));
          dat(8'($urandom));
          cmd(8'h00);
        end
        5: partial_byte($urandom_range(1, 7));
        default: lcd_reset_pulse();
      endcase
    end

    // Asynchronous system reset in the middle of a pixel.
    cmd(8'h2C);
    dat(8'hC3);
    @(negedge SYSTEM_CLK);
    RESET_N = 1'b0;
    #2;
    chk("async_rst_cmd", {24'd0, CMD}, 32'h00);
    chk("async_rst_pixel_data", {16'd0, PIXEL_DATA}, 32'd0);
    chk("async_rst_pixel_x", {24'd0, PIXEL_X}, 32'd0);
    model_swreset();
    m_last_cmd = 8'h00;
    @(negedge SYSTEM_CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge SYSTEM_CLK);
    dat(8'h12);
    cmd(8'h2C);
    pixel(16'hBEEF);

    repeat (20) @(negedge SYSTEM_CLK);
    chk("cmd_queue_drained", cmd_q.size(), 32'd0);
    chk("pixel_queue_drained", pix_q.size(), 32'd0);
    chk("cmd_held_final", {24'd0, CMD}, {24'd0, m_last_cmd});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/st7735_spi_decoder.md
ST7735_SPI_DECODER -- requirements
Module: st7735_spi_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 128, panel columns; reset/SWRESET column end = WIDTH-1.
REQ-002 SHALL have parameter HEIGHT, default 160, panel rows; reset/SWRESET row end = HEIGHT-1.
REQ-003 SHALL have port SYSTEM_CLK  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low system reset.
REQ-005 SHALL have port CS  input  1  SPI chip select from driver, active-low, asynchronous to SYSTEM_CLK.
REQ-006 SHALL have port LCD_CLK  input  1  SPI clock, MOSI sampled on its rising edge.
REQ-007 SHALL have port MOSI  input  1  serial data, MSB first.
REQ-008 SHALL have port DC  input  1  0 = command byte, 1 = data byte; sampled with the byte's 8th bit.
REQ-009 SHALL have port LCD_RESET  input  1  panel reset pin, active-low, asynchronous to SYSTEM_CLK.
REQ-010 SHALL have port CMD_VALID  output  1  one-cycle pulse per received command byte.
REQ-011 SHALL have port CMD  output  8  last command code, held until the next command.
REQ-012 SHALL have port PIXEL_VALID  output  1  one-cycle pulse per completed RGB565 pixel.
REQ-013 SHALL have ports PIXEL_X  output  8, PIXEL_Y  output  8, PIXEL_DATA  output  16  pixel coordinate and colour, valid with PIXEL_VALID.

Function
REQ-014 SHALL pass CS, LCD_CLK, MOSI, DC, LCD_RESET through two-flop synchronisers; supported LCD_CLK <= SYSTEM_CLK/4.
REQ-015 SHALL detect LCD_CLK rising edges on synchronised samples and shift MOSI into an 8-bit register only while CS is low.
REQ-016 SHALL, on the 8th bit, form a byte (first bit = bit 7) and present it internally for exactly one cycle, 1 cycle after the detected edge.
REQ-017 SHALL clear the bit counter whenever CS is high; a partial byte is discarded and decoder state is kept.
REQ-018 SHALL run FSM states IDLE, CASET_P, RASET_P, RAMWR_HI, RAMWR_LO; any command byte leaves the current state.
REQ-019 SHALL on command 0x2A enter CASET_P with parameter index 0; data bytes 0..3 load XS[15:8], XS[7:0], XE[15:8], XE[7:0]; after index 3 -> IDLE.
REQ-020 SHALL on command 0x2B handle RASET_P identically for YS/YE.
REQ-021 SHALL keep XS/XE/YS/YE 16 bits wide; PIXEL_X/PIXEL_Y are the low 8 bits of the current counters.
REQ-022 SHALL on command 0x2C set current X=XS, Y=YS and enter RAMWR_HI.
REQ-023 SHALL in RAMWR_HI latch the data byte as PIXEL_DATA[15:8] -> RAMWR_LO; in RAMWR_LO complete PIXEL_DATA[7:0], pulse PIXEL_VALID, -> RAMWR_HI.
REQ-024 SHALL advance after each pixel: X==XE -> X=XS and Y increments; Y==YE at that point -> Y=YS (frame wrap).
REQ-025 SHALL on command 0x01 (SWRESET) set XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1 and go to IDLE.
REQ-026 SHALL pulse CMD_VALID and update CMD for every command, including 0x01/0x2A/0x2B/0x2C; other codes -> IDLE, parameters ignored.
REQ-027 SHALL ignore data bytes in IDLE.
REQ-028 SHALL treat a new command arriving in RAMWR_LO as discarding the half pixel; no PIXEL_VALID.
REQ-029 SHALL treat synchronised LCD_RESET low as SWRESET plus bit counter clear, held while low; CMD_VALID not pulsed.

Reset
REQ-030 SHALL on RESET_N low asynchronously force CMD_VALID=0, PIXEL_VALID=0, CMD=0x00, PIXEL_X=0, PIXEL_Y=0, PIXEL_DATA=0, FSM=IDLE, bit counter=0, synchronisers to idle (CS=1, LCD_CLK=0, LCD_RESET=1), window = SWRESET values.
REQ-031 SHALL abandon any byte or pixel in progress on reset; release takes effect at the first SYSTEM_CLK edge after RESET_N rises.

Structure
REQ-032 SHALL take command codes (0x01, 0x2A, 0x2B, 0x2C) and the FSM state encoding from a shared ST7735 constants package used by the driver.
REQ-033 SHALL contain one sub-module, spi_byte_rx (synchronisers, edge detect, shifter, bit counter, byte strobe with DC flag).

Verification
REQ-034 SHALL: reset, send command 0x2A with data 00 02 00 05 -> CMD_VALID once with CMD=0x2A; XS=2, XE=5.
REQ-035 SHALL: after REQ-034 window, 0x2B data 00 03 00 04, 0x2C, 8 pixels 0xF800 -> PIXEL_VALID x8 at (2,3),(3,3),(4,3),(5,3),(2,4)..(5,4) with PIXEL_DATA=0xF800.
REQ-036 SHALL: continue with 1 more pixel 0x07E0 -> wrap to (2,3), data 0x07E0.
REQ-037 SHALL: CS high after 5 bits, then full byte 0x2C with DC=0 -> only 0x2C decoded, no spurious byte.
REQ-038 SHALL: 0x2C, byte 0xAB, then command 0x00 -> no PIXEL_VALID; CMD=0x00; FSM IDLE.
REQ-039 SHALL: 0x01 (or LCD_RESET low 10 cycles) then 0x2C + 1 pixel 0x001F -> pixel at (0,0); subsequent wrap at X=127, Y=159.
